// File: rtl/egress_port_sink.sv
// egress_port_sink: per-port store-and-forward sink downstream of the switch core.
//   Validates framing/header, stores packets, and rolls back and drops bad packets.
//   Latency: eop accepted to out_vld is 2 cycles on an empty FIFO. Output is first-word
//   fall-through from a registered output stage.
//   Backpressure: out_rdy stalls the output stage. ready[p] is registered from
//   ~pause[p] and free >= pkt_max_words; the core may still land one packet after ready drops.
// Ports: clk, rst_n (async active-low); rd_sop/rd_eop/rd_vld/rd_data from core;
//   pause -> ready per priority; out_sop/out_eop/out_vld/out_data/out_prio with out_rdy;
//   err_pulse on every drop.
// Optional: `define EGRESS_STATS_EN adds saturating pkt_cnt/err_cnt outputs.
module egress_port_sink #(
  parameter int data_width        = 16,
  parameter int num_of_priorities = 8,
  parameter int port_id           = 0,
  parameter int fifo_depth        = 128,
  parameter int pkt_max_words     = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_sop,
  input  logic                         rd_eop,
  input  logic                         rd_vld,
  input  logic [data_width-1:0]        rd_data,
  input  logic [num_of_priorities-1:0] pause,
  output logic [num_of_priorities-1:0] ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic                         out_vld,
  output logic [data_width-1:0]        out_data,
  output logic [2:0]                   out_prio,
  input  logic                         out_rdy,
  output logic                         err_pulse
`ifdef EGRESS_STATS_EN
  ,
  output logic [15:0]                  pkt_cnt,
  output logic [15:0]                  err_cnt
`endif
);

  localparam int AW = $clog2(fifo_depth);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(fifo_depth);
  localparam logic [PW-1:0] MAXW_P  = PW'(pkt_max_words);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
  state_t state, state_nxt;

  logic [data_width+1:0] mem [fifo_depth];
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, free;
  logic [8:0]    len_r, cnt_r;

  logic [8:0] hdr_len;
  logic [3:0] hdr_dest;
  logic       hdr_bad, pay_err;
  logic       wr_en, commit, rewind, err_now, load_hdr, cnt_inc;
  logic       ld;
  logic [data_width+1:0] rd_word;

  assign hdr_len  = rd_data[15:7];
  assign hdr_dest = rd_data[3:0];
  assign free     = DEPTH_P - (wr_ptr - rd_ptr);

  // A header is refused outright if it is misrouted, has an illegal length, or the
  // FIFO has no room even for the header word.
  assign hdr_bad = (hdr_dest != 4'(port_id)) || (hdr_len == 9'd0) ||
                   (hdr_len > 9'(pkt_max_words)) || (free == '0);

  assign pay_err = rd_sop || (free == '0) ||
                   (rd_eop  && (cnt_r + 9'd1 != len_r)) ||
                   (!rd_eop && (cnt_r + 9'd1 == len_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rewind    = 1'b0;
    err_now   = 1'b0;
    load_hdr  = 1'b0;
    cnt_inc   = 1'b0;
    if (rd_vld) begin
      unique case (state)
        IDLE, DROP: begin
          // DROP treats a new sop exactly like IDLE does.
          if (rd_sop) begin
            if (hdr_bad) begin
              err_now   = 1'b1;
              state_nxt = rd_eop ? IDLE : DROP;
            end else if (rd_eop) begin
              // Single-word packet: legal only when the header says len==1.
              if (hdr_len == 9'd1) begin
                wr_en  = 1'b1;
                commit = 1'b1;
              end else begin
                err_now = 1'b1;
              end
              state_nxt = IDLE;
            end else begin
              wr_en     = 1'b1;
              load_hdr  = 1'b1;
              state_nxt = PAYLOAD;
            end
          end else if (state == IDLE) begin
            err_now = 1'b1;           // stray word with no sop
          end else if (rd_eop) begin
            state_nxt = IDLE;
          end
        end
        PAYLOAD: begin
          if (pay_err) begin
            err_now   = 1'b1;
            rewind    = 1'b1;
            // An early eop already ends the bad packet; nothing left to discard.
            state_nxt = rd_eop ? IDLE : DROP;
          end else begin
            wr_en   = 1'b1;
            cnt_inc = 1'b1;
            if (rd_eop) begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {rd_sop, rd_eop, rd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len_r      <= '0;
      cnt_r      <= '0;
      err_pulse  <= 1'b0;
      ready      <= '0;
    end else begin
      if (rewind)     wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit)     commit_ptr <= wr_ptr + 1'b1;
      if (load_hdr) begin
        len_r <= hdr_len;
        cnt_r <= 9'd1;
      end else if (cnt_inc) begin
        cnt_r <= cnt_r + 9'd1;
      end
      err_pulse <= err_now;
      ready     <= ~pause & {num_of_priorities{free >= MAXW_P}};
    end
  end

  // Output stage: refill whenever it is empty or its word is leaving this cycle.
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign ld      = (rd_ptr != commit_ptr) && (!out_vld || out_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      out_vld  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_data <= '0;
      out_prio <= '0;
    end else if (ld) begin
      rd_ptr   <= rd_ptr + 1'b1;
      out_vld  <= 1'b1;
      out_sop  <= rd_word[data_width+1];
      out_eop  <= rd_word[data_width];
      out_data <= rd_word[data_width-1:0];
      if (rd_word[data_width+1]) out_prio <= rd_word[6:4];
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

`ifdef EGRESS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (commit  && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      if (err_now && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_egress_port_sink.sv
module tb_egress_port_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_sop, rd_eop, rd_vld;
  logic [15:0] rd_data;
  logic [7:0]  pause;
  logic [7:0]  ready;
  logic        out_sop, out_eop, out_vld;
  logic [15:0] out_data;
  logic [2:0]  out_prio;
  logic        out_rdy;
  logic        err_pulse;
`ifdef EGRESS_STATS_EN
  logic [15:0] pkt_cnt, err_cnt;
`endif

  egress_port_sink dut (
    .clk(clk), .rst_n(rst_n),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
    .pause(pause), .ready(ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld),
    .out_data(out_data), .out_prio(out_prio), .out_rdy(out_rdy),
    .err_pulse(err_pulse)
`ifdef EGRESS_STATS_EN
    , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int err_seen = 0;
  int first_vld_cyc = -1;
  logic [17:0] got_q[$];
  logic [2:0]  gotp_q[$];
  logic [17:0] exp_q[$];
  logic [2:0]  expp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld && out_rdy) begin
        got_q.push_back({out_sop, out_eop, out_data});
        gotp_q.push_back(out_prio);
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (err_pulse) err_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] hdr(input int len, input int prio, input int dest);
    return {9'(len), 3'(prio), 4'(dest)};
  endfunction

  task automatic idle(input int n);
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic [15:0] d);
    rd_vld = 1'b1; rd_sop = s; rd_eop = e; rd_data = d;
    @(posedge clk); #1;
  endtask

  // nwords words: header first, then base+i; the last word carries eop.
  task automatic send_pkt(input int len, input int prio, input int dest, input int nwords,
                          input logic [15:0] base, input bit expect_out);
    logic [15:0] d;
    for (int i = 0; i < nwords; i++) begin
      d = (i == 0) ? hdr(len, prio, dest) : base + 16'(i);
      if (expect_out) begin
        exp_q.push_back({(i == 0), (i == nwords - 1), d});
        expp_q.push_back(3'(prio));
      end
      drive(i == 0, i == nwords - 1, d);
    end
    idle(1);
  endtask

  task automatic compare_out(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_prio%0d", tag, i), 32'(gotp_q[i]), 32'(expp_q[i]));
    end
    got_q.delete(); gotp_q.delete(); exp_q.delete(); expp_q.delete();
  endtask

  int e0, eop_cyc;

  initial begin
    rst_n = 1'b0; rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = '0;
    pause = 8'h00; out_rdy = 1'b1;

    // 1: reset state, ready rises one clock after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 8'h00);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_err", err_pulse, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", ready, 8'hFF);
    check("empty_after_rst", out_vld, 1'b0);

    // 2: basic 4-word packet, latency from eop
    first_vld_cyc = -1;
    exp_q.push_back({1'b1, 1'b0, hdr(4, 5, 0)}); expp_q.push_back(3'd5);
    drive(1'b1, 1'b0, hdr(4, 5, 0));
    exp_q.push_back({1'b0, 1'b0, 16'hA001}); expp_q.push_back(3'd5);
    drive(1'b0, 1'b0, 16'hA001);
    exp_q.push_back({1'b0, 1'b0, 16'hA002}); expp_q.push_back(3'd5);
    drive(1'b0, 1'b0, 16'hA002);
    exp_q.push_back({1'b0, 1'b1, 16'hA003}); expp_q.push_back(3'd5);
    eop_cyc = cyc;
    drive(1'b0, 1'b1, 16'hA003);
    idle(8);
    check("t2_latency", 32'(first_vld_cyc - eop_cyc), 32'd2);
    check("t2_no_err", err_seen, 0);
    compare_out("t2");
`ifdef EGRESS_STATS_EN
    check("t2_pkt_cnt", pkt_cnt, 16'd1);
`endif

    // 3: wrong destination dropped, following packet intact
    e0 = err_seen;
    send_pkt(3, 2, 3, 3, 16'hB000, 1'b0);
    send_pkt(2, 1, 0, 2, 16'hC000, 1'b1);
    idle(6);
    check("t3_err_once", err_seen - e0, 1);
    compare_out("t3");
`ifdef EGRESS_STATS_EN
    check("t3_err_cnt", err_cnt, 16'd1);
`endif

    // 4: early eop rolled back; then length/framing boundaries
    e0 = err_seen;
    send_pkt(5, 3, 0, 3, 16'hD000, 1'b0);
    send_pkt(3, 6, 0, 3, 16'hE000, 1'b1);
    idle(6);
    check("t4_err_early_eop", err_seen - e0, 1);
    compare_out("t4");
    e0 = err_seen;
    send_pkt(1, 7, 0, 1, 16'h0000, 1'b1);   // len 1, sop+eop: legal
    send_pkt(2, 1, 0, 1, 16'h0000, 1'b0);   // sop+eop but len 2: drop
    send_pkt(0, 1, 0, 2, 16'h6000, 1'b0);   // len 0: drop
    drive(1'b0, 1'b0, 16'h7777);            // stray word in IDLE: drop
    idle(6);
    check("t4_err_bounds", err_seen - e0, 3);
    compare_out("t4b");
`ifdef EGRESS_STATS_EN
    check("t4_err_cnt", err_cnt, 16'd5);
    check("t4_pkt_cnt", pkt_cnt, 16'd4);
`endif

    // 5: fill with two max-length packets while stalled, then drain
    out_rdy = 1'b0;
    send_pkt(64, 2, 0, 64, 16'h1000, 1'b1);
    idle(3);
    check("t5_ready_one_pkt", ready, 8'hFF);
    send_pkt(64, 3, 0, 64, 16'h2000, 1'b1);
    idle(2);
    check("t5_ready_full", ready, 8'h00);
    out_rdy = 1'b1;
    idle(140);
    compare_out("t5");
    check("t5_ready_drained", ready, 8'hFF);

    // 6: pause mask, then reset with a stuck packet and one in flight
    pause = 8'h04;
    out_rdy = 1'b0;
    idle(2);
    check("t6_pause", ready, 8'hFB);
    send_pkt(2, 3, 0, 2, 16'h3000, 1'b0);
    exp_q.delete(); expp_q.delete();
    drive(1'b1, 1'b0, hdr(4, 2, 0));
    drive(1'b0, 1'b0, 16'h4001);
    #2 rst_n = 1'b0;
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
    #1;
    check("t6_rst_ready", ready, 8'h00);
    check("t6_rst_vld", out_vld, 1'b0);
    check("t6_rst_data", out_data, 16'h0000);
    check("t6_rst_prio", out_prio, 3'd0);
    check("t6_rst_sop", out_sop, 1'b0);
    check("t6_rst_err", err_pulse, 1'b0);
    pause = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    got_q.delete(); gotp_q.delete();
    e0 = err_seen;
    idle(5);
    check("t6_fifo_empty", got_q.size(), 0);
    send_pkt(2, 4, 0, 2, 16'h5000, 1'b1);
    idle(6);
    compare_out("t6");
    check("t6_no_err", err_seen - e0, 0);
    check("t6_ready", ready, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
